// File: rtl/fb_draw_controller.sv
// Frame draw sequencer: copies a scrolled window of the map image into the
// framebuffer, then overlays the player sprite with colour-key transparency.
// ROM reads are issued one per cycle; the matching framebuffer write follows
// one cycle later through a single-entry valid/address pipeline.
module fb_draw_controller #(
  parameter int unsigned FB_W      = 240,
  parameter int unsigned FB_H      = 160,
  parameter int unsigned MAP_W     = 480,
  parameter int unsigned MAP_H     = 320,
  parameter int unsigned SPR       = 16,
  parameter int unsigned PLAYER_X  = 112,
  parameter int unsigned PLAYER_Y  = 72,
  parameter logic [23:0] KEY_COLOR = 24'hFF00FF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic [9:0]  scroll_x,
  input  logic [9:0]  scroll_y,
  input  logic [1:0]  playerDir,
  output logic [18:0] map_raddr,
  input  logic [23:0] map_rdata,
  output logic [9:0]  spr_raddr,
  input  logic [23:0] spr_rdata,
  output logic        fb_we,
  output logic [18:0] fb_waddr,
  output logic [23:0] fb_wdata,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam logic [9:0] MaxSx = 10'(MAP_W - FB_W);
  localparam logic [9:0] MaxSy = 10'(MAP_H - FB_H);
  localparam logic [9:0] LastX = 10'(FB_W - 1);
  localparam logic [9:0] LastY = 10'(FB_H - 1);
  localparam logic [9:0] LastS = 10'(SPR - 1);

  typedef enum logic [1:0] {StIdle, StMap, StChar, StDone} state_e;

  state_e      state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        drain_q, drain_d;
  logic [9:0]  sx_q, sx_d, sy_q, sy_d;
  logic [1:0]  dir_q, dir_d;
  logic        wr_valid_q, wr_valid_d;
  logic        wr_spr_q, wr_spr_d;
  logic [18:0] wr_addr_q, wr_addr_d;
  logic        overrun_q, overrun_d;

  // Next-state: frame sequencing, read address generation and write pipeline load.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    drain_d    = drain_q;
    sx_d       = sx_q;
    sy_d       = sy_q;
    dir_d      = dir_q;
    wr_valid_d = 1'b0;
    wr_spr_d   = 1'b0;
    wr_addr_d  = '0;
    map_raddr  = '0;
    spr_raddr  = '0;
    // Any start pulse outside IDLE (DONE included) is dropped and flagged.
    overrun_d  = overrun_q | (frame_start & (state_q != StIdle));
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          sx_d    = (scroll_x > MaxSx) ? MaxSx : scroll_x;
          sy_d    = (scroll_y > MaxSy) ? MaxSy : scroll_y;
          dir_d   = playerDir;
          x_d     = '0;
          y_d     = '0;
          drain_d = 1'b0;
          state_d = StMap;
        end
      end
      StMap: begin
        if (drain_q) begin
          // Last map write is on the bus this cycle; no new read.
          drain_d = 1'b0;
          x_d     = '0;
          y_d     = '0;
          state_d = StChar;
        end else begin
          map_raddr  = (19'(y_q) + 19'(sy_q)) * 19'(MAP_W) + 19'(x_q) + 19'(sx_q);
          wr_valid_d = 1'b1;
          wr_addr_d  = 19'(y_q) * 19'(FB_W) + 19'(x_q);
          if (x_q == LastX) begin
            x_d = '0;
            if (y_q == LastY) drain_d = 1'b1;
            else              y_d = y_q + 10'd1;
          end else begin
            x_d = x_q + 10'd1;
          end
        end
      end
      StChar: begin
        if (drain_q) begin
          drain_d = 1'b0;
          state_d = StDone;
        end else begin
          spr_raddr  = 10'(dir_q) * 10'(SPR * SPR) + y_q * 10'(SPR) + x_q;
          wr_valid_d = 1'b1;
          wr_spr_d   = 1'b1;
          wr_addr_d  = (19'(PLAYER_Y) + 19'(y_q)) * 19'(FB_W) + 19'(PLAYER_X) + 19'(x_q);
          if (x_q == LastS) begin
            x_d = '0;
            if (y_q == LastS) drain_d = 1'b1;
            else              y_d = y_q + 10'd1;
          end else begin
            x_d = x_q + 10'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StIdle;
      x_q        <= '0;
      y_q        <= '0;
      drain_q    <= 1'b0;
      sx_q       <= '0;
      sy_q       <= '0;
      dir_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_spr_q   <= 1'b0;
      wr_addr_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      drain_q    <= drain_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      dir_q      <= dir_d;
      wr_valid_q <= wr_valid_d;
      wr_spr_q   <= wr_spr_d;
      wr_addr_q  <= wr_addr_d;
      overrun_q  <= overrun_d;
    end
  end

  // Write port: ROM data arrives the cycle after its read; keyed sprite pixels are skipped.
  always_comb begin
    fb_we    = wr_valid_q & (~wr_spr_q | (spr_rdata != KEY_COLOR));
    fb_waddr = wr_valid_q ? wr_addr_q : '0;
    fb_wdata = '0;
    if (wr_valid_q) fb_wdata = wr_spr_q ? spr_rdata : map_rdata;
    busy     = (state_q != StIdle);
    done     = (state_q == StDone);
    overrun  = overrun_q;
  end

endmodule

// File: doc/fb_draw_controller.md
FB_DRAW_CONTROLLER -- requirements
Module: fb_draw_controller

Interface
REQ-001 SHALL have parameters: FB_W 240, framebuffer width in pixels; FB_H 160, framebuffer height; MAP_W 480, map image width; MAP_H 320, map image height; SPR 16, sprite edge length; PLAYER_X 112, sprite left column in framebuffer; PLAYER_Y 72, sprite top row; KEY_COLOR 24'hFF00FF, transparent sprite colour.
REQ-002 SHALL have ports (name, direction, width, meaning):
- Clk  in  1  sole clock.
- Reset  in  1  synchronous, active-high.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- scroll_x  in  10  map column of the framebuffer's left edge.
- scroll_y  in  10  map row of the framebuffer's top edge.
- playerDir  in  2  sprite frame select.
- map_raddr  out  19  map ROM read address.
- map_rdata  in  24  map ROM data, one-cycle latency.
- spr_raddr  out  10  sprite ROM read address.
- spr_rdata  in  24  sprite ROM data, one-cycle latency.
- fb_we  out  1  framebuffer write enable.
- fb_waddr  out  19  framebuffer write address.
- fb_wdata  out  24  framebuffer write data.
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle pulse when a frame is complete.
- overrun  out  1  sticky flag: frame_start arrived while busy.

Function
REQ-003 SHALL implement the states IDLE, MAP, CHAR and DONE.
REQ-004 SHALL, in IDLE on frame_start, latch scroll_x, scroll_y and playerDir, clear the pixel counters, and enter MAP on the next cycle.
REQ-005 SHALL clamp scroll_x to MAP_W-FB_W (240) and scroll_y to MAP_H-FB_H (160) at latch time.
REQ-006 SHALL hold latched values constant for the whole frame, whatever the inputs do mid-frame.
REQ-007 SHALL, in MAP, issue one read per cycle in raster order (x 0..239 inner, y 0..159 outer), at map_raddr = (y+sy)*MAP_W + (x+sx), with all arithmetic at 19 bits.
REQ-008 SHALL register a valid bit and destination address alongside each read.
REQ-009 SHALL, the cycle after each read, drive fb_we=1, fb_waddr = y*FB_W + x, and fb_wdata = map_rdata.
REQ-010 SHALL, after the read for (239,159), spend one drain cycle completing the last write, then enter CHAR, so that MAP occupies 38400+1 cycles.
REQ-011 SHALL, in CHAR, read spr_raddr = dir*256 + sy*16 + sx for sx and sy in 0..15, raster order, one read per cycle.
REQ-012 SHALL make each CHAR write one cycle after its read, to address (PLAYER_Y+sy)*FB_W + (PLAYER_X+sx).
REQ-013 SHALL hold fb_we=0 for any CHAR pixel whose spr_rdata equals KEY_COLOR, while the address sequence continues unchanged.
REQ-014 SHALL, after the 256th sprite read plus one drain cycle, enter DONE.
REQ-015 SHALL, in DONE, assert done for exactly one cycle and return to IDLE on the next cycle.
REQ-016 SHALL therefore assert done 38659 cycles after the frame_start cycle.
REQ-017 SHALL never assert fb_we in IDLE or DONE, and never write more than one pixel per cycle.
REQ-018 SHALL, whenever frame_start=1 while busy=1, ignore the pulse (no restart, no relatch) and set overrun=1, which holds until Reset.
REQ-019 SHALL accept a frame_start arriving in the same cycle that DONE returns to IDLE as a new frame, not as an overrun.
REQ-020 SHALL drive map_raddr and spr_raddr to 0 when not reading.

Reset
REQ-021 SHALL, on Reset=1 at a Clk edge, enter IDLE and drive fb_we=0, busy=0, done=0, overrun=0, fb_waddr=0, fb_wdata=0, map_raddr=0 and spr_raddr=0, and clear the pipeline valid bit.
REQ-022 SHALL, on Reset mid-MAP or mid-CHAR, issue no framebuffer write in the cycle after Reset, including the in-flight pipelined pixel.
REQ-023 SHALL give Reset priority over a simultaneous frame_start.

Verification
REQ-024 SHALL cover: scroll 0,0, map_rdata = read address -> first write addr 0 data 0; write addr 1 data 1; last MAP write addr 38399 data 159*480+239=76559.
REQ-025 SHALL cover: scroll_x=300, scroll_y=200 -> clamped to 240 and 160; first map_raddr = 160*480+240 = 77040.
REQ-026 SHALL cover: playerDir=2, sprite data KEY_COLOR at every even sx -> first spr_raddr 512; exactly 128 CHAR writes, first to 72*240+113 = 17393.
REQ-027 SHALL cover: frame_start at 0, again at 1000 -> overrun=1 from cycle 1001; done single pulse at 38659; no restart.
REQ-028 SHALL cover: Reset at cycle 500 of MAP -> fb_we=0 from the next edge on; busy=0; a new frame_start then restarts at fb_waddr 0.
REQ-029 SHALL cover: frame_start in the cycle done is high, then the next cycle -> first pulse ignored as overrun; second starts a new frame with overrun staying 1.
